// File: rtl/overflow_timer.sv
// Prescaled up-counter that wraps to a reload value and raises a held OVERFLOW flag.
// Latency: OVERFLOW rises on the wrap edge; ACK clears it on the following edge.
// No backpressure: events are held until ACK, and a second unacknowledged event sets OVR_LOST.
module overflow_timer #(
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  EN,
    input  logic                  LOAD,
    input  logic [WIDTH-1:0]      LOAD_VAL,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    input  logic                  ACK,
    output logic                  OVERFLOW,
    output logic                  OVR_LOST,
    output logic [WIDTH-1:0]      COUNT
);

    typedef enum logic [1:0] {
        CLEAR   = 2'd0,
        PENDING = 2'd1,
        LOST    = 2'd2
    } flag_state_t;

    logic [PRESCALE_W-1:0] pre;
    logic [WIDTH-1:0]      reload;
    flag_state_t           state;
    flag_state_t           state_nxt;
    logic                  tick;
    logic                  ovf_evt;

    // A tick coinciding with LOAD is dropped, so it can never produce an overflow event.
    assign tick    = EN && (pre == PRESCALE);
    assign ovf_evt = tick && !LOAD && (COUNT == {WIDTH{1'b1}});

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pre    <= '0;
            reload <= '0;
            COUNT  <= '0;
        end else if (LOAD) begin
            pre    <= '0;
            reload <= LOAD_VAL;
            COUNT  <= LOAD_VAL;
        end else if (EN) begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) begin
                COUNT <= (COUNT == {WIDTH{1'b1}}) ? reload : COUNT + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (ovf_evt) state_nxt = PENDING;
            PENDING: begin
                if (ovf_evt && !ACK) state_nxt = LOST;
                else if (ovf_evt)    state_nxt = PENDING;
                else if (ACK)        state_nxt = CLEAR;
            end
            LOST: begin
                if (ovf_evt && ACK)  state_nxt = PENDING;
                else if (ACK)        state_nxt = CLEAR;
            end
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= CLEAR;
            OVERFLOW <= 1'b0;
            OVR_LOST <= 1'b0;
        end else begin
            state    <= state_nxt;
            OVERFLOW <= (state_nxt == PENDING) || (state_nxt == LOST);
            OVR_LOST <= (state_nxt == LOST);
        end
    end

endmodule

// File: tb/tb_overflow_timer.sv
// Directed bench for overflow_timer (WIDTH=4, PRESCALE_W=4) with a queue-based scoreboard.
module tb_overflow_timer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [3:0] lv = 4'h0;
    logic [3:0] ps = 4'h0;
    logic       ack = 1'b0;
    logic       ovf;
    logic       lost;
    logic [3:0] cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      nm;
        logic [3:0] c;
        logic       o;
        logic       l;
    } exp_t;

    exp_t q[$];

    overflow_timer #(.WIDTH(4), .PRESCALE_W(4)) dut (
        .CLK      (clk),
        .RESET    (rst_n),
        .EN       (en),
        .LOAD     (load),
        .LOAD_VAL (lv),
        .PRESCALE (ps),
        .ACK      (ack),
        .OVERFLOW (ovf),
        .OVR_LOST (lost),
        .COUNT    (cnt)
    );

    always #5 clk = ~clk;

    task automatic compare(input string nm, input logic [3:0] c, input logic o, input logic l);
        checks++;
        if (cnt !== c || ovf !== o || lost !== l) begin
            errors++;
            $display("FAIL %s: got count=%h ovf=%b lost=%b, want count=%h ovf=%b lost=%b",
                     nm, cnt, ovf, lost, c, o, l);
        end
    endtask

    // Monitor: every clock edge after reset is a DUT output sample; pop the matching expectation.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            compare(e.nm, e.c, e.o, e.l);
        end
    end

    // Push the expected post-edge state, then advance to the next falling edge to drive again.
    task automatic cyc(input string nm, input logic [3:0] c, input logic o, input logic l);
        exp_t e;
        e.nm = nm; e.c = c; e.o = o; e.l = l;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #1 compare("reset", 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: reload D, tick every cycle, wrap on the 3rd enabled edge, hold until ACK
        ps = 4'd0; lv = 4'hD; load = 1'b1;
        cyc("t1_load", 4'hD, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1;
        cyc("t1_e", 4'hE, 1'b0, 1'b0);
        cyc("t1_f", 4'hF, 1'b0, 1'b0);
        cyc("t1_wrap", 4'hD, 1'b1, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 10; i++) cyc($sformatf("t1_hold%0d", i), 4'hD, 1'b1, 1'b0);
        ack = 1'b1;
        cyc("t1_ack", 4'hD, 1'b0, 1'b0);
        ack = 1'b0;
        cyc("t1_ackidle", 4'hD, 1'b0, 1'b0);

        // 2: divide by 3, freeze for 5 cycles mid-phase, resume exactly
        ps = 4'd2; lv = 4'h0; load = 1'b1;
        cyc("t2_load", 4'h0, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1;
        cyc("t2_c1", 4'h0, 1'b0, 1'b0);
        cyc("t2_c2", 4'h0, 1'b0, 1'b0);
        cyc("t2_c3", 4'h1, 1'b0, 1'b0);
        cyc("t2_c4", 4'h1, 1'b0, 1'b0);
        cyc("t2_c5", 4'h1, 1'b0, 1'b0);
        cyc("t2_c6", 4'h2, 1'b0, 1'b0);
        cyc("t2_c7", 4'h2, 1'b0, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 5; i++) cyc($sformatf("t2_frz%0d", i), 4'h2, 1'b0, 1'b0);
        en = 1'b1;
        cyc("t2_res1", 4'h2, 1'b0, 1'b0);
        cyc("t2_res2", 4'h3, 1'b0, 1'b0);
        en = 1'b0;

        // 3: ACK arriving together with a new wrap keeps OVERFLOW without loss
        ps = 4'd0; lv = 4'hE; load = 1'b1;
        cyc("t3_load", 4'hE, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1;
        cyc("t3_f", 4'hF, 1'b0, 1'b0);
        cyc("t3_wrap1", 4'hE, 1'b1, 1'b0);
        cyc("t3_f2", 4'hF, 1'b1, 1'b0);
        ack = 1'b1;
        cyc("t3_wrapack", 4'hE, 1'b1, 1'b0);
        ack = 1'b0;

        // 4: second wrap without ACK sets the lost flag; one ACK clears both
        cyc("t4_f", 4'hF, 1'b1, 1'b0);
        cyc("t4_wrap2", 4'hE, 1'b1, 1'b1);
        en = 1'b0;
        cyc("t4_hold", 4'hE, 1'b1, 1'b1);
        ack = 1'b1;
        cyc("t4_ack", 4'hE, 1'b0, 1'b0);
        ack = 1'b0;

        // 5: LOAD beats a tick at F: no overflow, prescaler phase restarts
        ps = 4'd1; lv = 4'hE; load = 1'b1;
        cyc("t5_load", 4'hE, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1;
        cyc("t5_p1", 4'hE, 1'b0, 1'b0);
        cyc("t5_tf", 4'hF, 1'b0, 1'b0);
        cyc("t5_p2", 4'hF, 1'b0, 1'b0);
        lv = 4'h3; load = 1'b1;
        cyc("t5_ldtick", 4'h3, 1'b0, 1'b0);
        load = 1'b0;
        cyc("t5_p3", 4'h3, 1'b0, 1'b0);
        cyc("t5_t4", 4'h4, 1'b0, 1'b0);
        en = 1'b0;

        // 6: asynchronous reset with OVERFLOW set, then restart from 0
        ps = 4'd0; lv = 4'hF; load = 1'b1;
        cyc("t6_load", 4'hF, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1;
        cyc("t6_wrap", 4'hF, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 compare("t6_async_rst", 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc("t6_r1", 4'h1, 1'b0, 1'b0);
        cyc("t6_r2", 4'h2, 1'b0, 1'b0);
        cyc("t6_r3", 4'h3, 1'b0, 1'b0);

        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout at %0t, want completion", $time);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
